// File: rtl/note_scroll_if.sv
// Push handshake, read port and status bundle between the note scroller and
// its client (sequencer / sprite renderer).
interface note_scroll_if #(
  parameter int NOTE_W = 4,
  parameter int SLOT_W = 3,
  parameter int X_W    = 11,
  parameter int Y_W    = 10
);
  logic              in_valid;
  logic [NOTE_W-1:0] in_note;
  logic              in_ready;
  logic              frame_tick;
  logic              busy;
  logic [SLOT_W-1:0] rd_idx;
  logic              rd_valid;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic              hit_valid;
  logic [NOTE_W-1:0] hit_note;
  logic              miss_pulse;
  logic              bad_note;
  logic              overrun;

  modport master (
    output in_valid, in_note, frame_tick, rd_idx,
    input  in_ready, busy, rd_valid, rd_x, rd_y,
           hit_valid, hit_note, miss_pulse, bad_note, overrun
  );

  modport slave (
    input  in_valid, in_note, frame_tick, rd_idx,
    output in_ready, busy, rd_valid, rd_x, rd_y,
           hit_valid, hit_note, miss_pulse, bad_note, overrun
  );
endinterface

// File: rtl/note_scroll_engine.sv
// Per-frame note scroller: holds falling notes, shifts them left once per
// frame_tick in a slot-by-slot scan, retires notes leaving the screen and
// reports the leftmost note inside the hit window.
module note_scroll_engine #(
  parameter int NUM_SLOTS   = 8,
  parameter int NOTE_W      = 4,
  parameter int NUM_LANES   = 8,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int X_START     = 1023,
  parameter int SCROLL_STEP = 2,
  parameter int Y_TOP       = 40,
  parameter int Y_STEP      = 24,
  parameter int HIT_LO      = 90,
  parameter int HIT_HI      = 120
) (
  input  logic          clk,
  input  logic          reset,
  note_scroll_if.slave  bus
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [X_W-1:0]    X_START_V = X_W'(X_START);
  localparam logic [X_W-1:0]    STEP_V    = X_W'(SCROLL_STEP);
  localparam logic [X_W-1:0]    HIT_LO_V  = X_W'(HIT_LO);
  localparam logic [X_W-1:0]    HIT_HI_V  = X_W'(HIT_HI);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  logic [1:0]           r_state;
  logic [SLOT_W-1:0]    r_scan_idx;
  logic                 r_busy;
  logic [NUM_SLOTS-1:0] r_occ;
  logic [X_W-1:0]       r_x    [NUM_SLOTS];
  logic [NOTE_W-1:0]    r_note [NUM_SLOTS];
  logic [Y_W-1:0]       r_y    [NUM_SLOTS];
  logic                 r_best_found;
  logic [X_W-1:0]       r_best_x;
  logic [NOTE_W-1:0]    r_best_note;
  logic                 r_hit_valid;
  logic [NOTE_W-1:0]    r_hit_note;
  logic                 r_miss;
  logic                 r_bad;
  logic                 r_overrun;
  logic                 r_rd_valid;
  logic [X_W-1:0]       r_rd_x;
  logic [Y_W-1:0]       r_rd_y;

  logic [SLOT_W-1:0] w_free_idx;
  logic              w_any_free;
  logic              w_in_ready;
  logic              w_push;
  logic              w_note_ok;
  logic [Y_W-1:0]    w_push_y;
  logic              w_scanning;
  logic              w_cur_occ;
  logic [X_W-1:0]    w_cur_x;
  logic              w_retire;
  logic [X_W-1:0]    w_new_x;
  logic              w_in_win;
  logic              w_take;
  logic              w_rd_ok;

  // Lowest free slot; walking downward lets the lowest index win.
  always_comb begin
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_free_idx = r_occ[i] ? w_free_idx : SLOT_W'(i);
    end
  end

  assign w_any_free = ~(&r_occ);
  assign w_in_ready = (r_state == ST_IDLE) && !bus.frame_tick && w_any_free;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_note_ok  = (32'(bus.in_note) < NUM_LANES);
  assign w_push_y   = Y_W'(Y_TOP) + (Y_W'(bus.in_note) * Y_W'(Y_STEP));

  // Slot currently visited by the scan and its post-scroll position.
  assign w_scanning = (r_state == ST_SCAN);
  assign w_cur_occ  = r_occ[r_scan_idx];
  assign w_cur_x    = r_x[r_scan_idx];
  assign w_retire   = w_cur_occ && (w_cur_x < STEP_V);
  assign w_new_x    = w_cur_x - STEP_V;
  assign w_in_win   = w_cur_occ && !w_retire && (w_new_x >= HIT_LO_V) && (w_new_x <= HIT_HI_V);
  // Strict less-than: slots are visited in ascending order, so ties keep the lower index.
  assign w_take     = w_scanning && w_in_win && (!r_best_found || (w_new_x < r_best_x));
  assign w_rd_ok    = (32'(bus.rd_idx) < NUM_SLOTS);

  // Frame FSM: IDLE -> SCAN (one slot per cycle) -> DONE -> IDLE, plus hit tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_scan_idx   <= '0;
      r_busy       <= 1'b0;
      r_best_found <= 1'b0;
      r_best_x     <= '0;
      r_best_note  <= '0;
      r_hit_valid  <= 1'b0;
      r_hit_note   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.frame_tick) begin
            r_state      <= ST_SCAN;
            r_busy       <= 1'b1;
            r_scan_idx   <= '0;
            r_best_found <= 1'b0;
            r_best_x     <= '0;
            r_best_note  <= '0;
          end
        end
        ST_SCAN: begin
          if (w_take) begin
            r_best_found <= 1'b1;
            r_best_x     <= w_new_x;
            r_best_note  <= r_note[r_scan_idx];
          end
          if (r_scan_idx == LAST_SLOT) begin
            r_state <= ST_DONE;
          end else begin
            r_scan_idx <= r_scan_idx + SLOT_W'(1);
          end
        end
        ST_DONE: begin
          r_hit_valid <= r_best_found;
          r_hit_note  <= r_best_found ? r_best_note : '0;
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Slot storage: pushes fill the lowest free slot, the scan scrolls or retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_x[i]    <= '0;
        r_note[i] <= '0;
        r_y[i]    <= '0;
      end
    end else if (w_push && w_note_ok) begin
      r_occ[w_free_idx]  <= 1'b1;
      r_x[w_free_idx]    <= X_START_V;
      r_note[w_free_idx] <= bus.in_note;
      r_y[w_free_idx]    <= w_push_y;
    end else if (w_scanning && w_cur_occ) begin
      if (w_retire) begin
        r_occ[r_scan_idx] <= 1'b0;
        r_x[r_scan_idx]   <= '0;
      end else begin
        r_x[r_scan_idx] <= w_new_x;
      end
    end
  end

  // Event pulses and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_miss    <= 1'b0;
      r_bad     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_miss    <= w_scanning && w_retire;
      r_bad     <= w_push && !w_note_ok;
      r_overrun <= r_overrun || (bus.frame_tick && (r_state != ST_IDLE));
    end
  end

  // Registered read port; empty or out-of-range slots read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_x     <= '0;
      r_rd_y     <= '0;
    end else if (w_rd_ok && r_occ[bus.rd_idx]) begin
      r_rd_valid <= 1'b1;
      r_rd_x     <= r_x[bus.rd_idx];
      r_rd_y     <= r_y[bus.rd_idx];
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_x     <= '0;
      r_rd_y     <= '0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = r_busy;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_x       = r_rd_x;
  assign bus.rd_y       = r_rd_y;
  assign bus.hit_valid  = r_hit_valid;
  assign bus.hit_note   = r_hit_note;
  assign bus.miss_pulse = r_miss;
  assign bus.bad_note   = r_bad;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_note_scroll_engine.sv
// Self-checking bench for note_scroll_engine: vector table for the push
// handshake, directed multi-frame sequences and a randomized phase, all
// compared against a slot-array reference model.
module tb_note_scroll_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  note_scroll_if bus ();

  note_scroll_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_occ  [8];
  int m_x    [8];
  int m_note [8];
  int m_hit_valid;
  int m_hit_note;
  int m_overrun;

  typedef struct {
    logic [3:0] note;
    logic       exp_ready;
    logic       exp_bad;
  } push_vec_t;

  push_vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_free_cnt();
    int c = 0;
    for (int i = 0; i < 8; i++) if (m_occ[i] == 0) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_occ[i] = 0; m_x[i] = 0; m_note[i] = 0;
    end
    m_hit_valid = 0; m_hit_note = 0; m_overrun = 0;
  endtask

  task automatic model_insert(input int note);
    for (int i = 0; i < 8; i++) begin
      if (m_occ[i] == 0) begin
        m_occ[i] = 1; m_x[i] = 1023; m_note[i] = note;
        return;
      end
    end
  endtask

  // One frame: scroll every note, count departures, then pick the hit note.
  task automatic model_frame(output int misses);
    int best;
    misses = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_occ[i] != 0) begin
        if (m_x[i] - 2 < 0) begin
          m_occ[i] = 0; m_x[i] = 0; misses++;
        end else begin
          m_x[i] = m_x[i] - 2;
        end
      end
    end
    best = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_occ[i] != 0 && m_x[i] >= 90 && m_x[i] <= 120) begin
        if (best < 0 || m_x[i] < m_x[best]) best = i;
      end
    end
    m_hit_valid = (best >= 0) ? 1 : 0;
    m_hit_note  = (best >= 0) ? m_note[best] : 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.frame_tick = 1'b0; bus.in_note = 4'd0; bus.rd_idx = 3'd0;
    tick_clk();
    tick_clk();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_push(input int note);
    int exp_ready;
    exp_ready = (model_free_cnt() > 0) ? 1 : 0;
    bus.in_valid = 1'b1;
    bus.in_note  = 4'(note);
    #1;
    chk("push_in_ready", 32'(bus.in_ready), exp_ready);
    tick_clk();
    bus.in_valid = 1'b0;
    chk("push_bad_note", 32'(bus.bad_note), (exp_ready == 1 && note >= 8) ? 1 : 0);
    if (exp_ready == 1 && note < 8) model_insert(note);
  endtask

  task automatic read_slot(input int i);
    bus.rd_idx = 3'(i);
    tick_clk();
    chk("rd_valid", 32'(bus.rd_valid), m_occ[i]);
    chk("rd_x", 32'(bus.rd_x), (m_occ[i] != 0) ? m_x[i] : 0);
    chk("rd_y", 32'(bus.rd_y), (m_occ[i] != 0) ? (40 + 24 * m_note[i]) : 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) read_slot(i);
  endtask

  // Wait out a scan already started; returns busy length, miss and in_ready counts.
  task automatic wait_scan(output int cyc, output int misses, output int rdy);
    cyc = 0; misses = 0; rdy = 0;
    while (bus.busy && cyc < 20) begin
      cyc++;
      misses += 32'(bus.miss_pulse);
      rdy    += 32'(bus.in_ready);
      tick_clk();
    end
  endtask

  task automatic do_frame();
    int exp_miss, cyc, misses, rdy;
    model_frame(exp_miss);
    bus.frame_tick = 1'b1;
    #1;
    chk("ready_low_on_tick", 32'(bus.in_ready), 0);
    tick_clk();
    bus.frame_tick = 1'b0;
    wait_scan(cyc, misses, rdy);
    chk("busy_cycles", cyc, 9);
    chk("miss_count", misses, exp_miss);
    chk("ready_during_busy", rdy, 0);
    chk("hit_valid", 32'(bus.hit_valid), m_hit_valid);
    chk("hit_note", 32'(bus.hit_note), m_hit_note);
    chk("overrun", 32'(bus.overrun), m_overrun);
    chk("ready_after_frame", 32'(bus.in_ready), (model_free_cnt() > 0) ? 1 : 0);
  endtask

  initial begin
    int cyc, misses, rdy, r;

    tbl[0]  = '{4'd9,  1'b1, 1'b1};
    tbl[1]  = '{4'd0,  1'b1, 1'b0};
    tbl[2]  = '{4'd1,  1'b1, 1'b0};
    tbl[3]  = '{4'd2,  1'b1, 1'b0};
    tbl[4]  = '{4'd3,  1'b1, 1'b0};
    tbl[5]  = '{4'd4,  1'b1, 1'b0};
    tbl[6]  = '{4'd5,  1'b1, 1'b0};
    tbl[7]  = '{4'd6,  1'b1, 1'b0};
    tbl[8]  = '{4'd7,  1'b1, 1'b0};
    tbl[9]  = '{4'd1,  1'b0, 1'b0};
    tbl[10] = '{4'd12, 1'b0, 1'b0};

    // Reset state
    do_reset();
    tick_clk();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_hit_valid", 32'(bus.hit_valid), 0);
    chk("rst_hit_note", 32'(bus.hit_note), 0);
    chk("rst_miss", 32'(bus.miss_pulse), 0);
    chk("rst_bad", 32'(bus.bad_note), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_x", 32'(bus.rd_x), 0);
    chk("rst_rd_y", 32'(bus.rd_y), 0);

    // Single push, readback, one frame
    do_push(3);
    bus.rd_idx = 3'd0;
    tick_clk();
    chk("t1_rd_valid", 32'(bus.rd_valid), 1);
    chk("t1_rd_x", 32'(bus.rd_x), 1023);
    chk("t1_rd_y", 32'(bus.rd_y), 112);
    do_frame();
    bus.rd_idx = 3'd0;
    tick_clk();
    chk("t2_rd_x", 32'(bus.rd_x), 1021);

    // Handshake table: bad note into empty engine, fill, refuse when full
    do_reset();
    for (int v = 0; v < 11; v++) begin
      bus.in_valid = 1'b1;
      bus.in_note  = tbl[v].note;
      #1;
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[v].exp_ready));
      tick_clk();
      bus.in_valid = 1'b0;
      chk("tbl_bad_note", 32'(bus.bad_note), 32'(tbl[v].exp_bad));
      if (tbl[v].exp_ready && tbl[v].note < 4'd8) model_insert(32'(tbl[v].note));
      tick_clk();
      chk("tbl_bad_low", 32'(bus.bad_note), 0);
    end
    chk("full_in_ready", 32'(bus.in_ready), 0);
    read_all();

    // Hit window, ties and retirement over a long run of frames
    do_reset();
    do_push(5);
    for (int f = 0; f < 8; f++) do_frame();
    do_push(2); do_push(0); do_push(1); do_push(3); do_push(4); do_push(6); do_push(7);
    do_push(1);
    for (int f = 8; f < 463; f++) do_frame();
    chk("t5_hit_valid", 32'(bus.hit_valid), 1);
    chk("t5_hit_note", 32'(bus.hit_note), 5);
    read_slot(0);
    chk("t5_x0", 32'(bus.rd_x), 97);
    read_slot(1);
    chk("t5_x1", 32'(bus.rd_x), 113);
    for (int f = 463; f < 467; f++) do_frame();
    chk("t5_tie_note", 32'(bus.hit_note), 2);
    for (int f = 467; f < 511; f++) do_frame();
    read_slot(0);
    chk("t4_x_one", 32'(bus.rd_x), 1);
    chk("t4_full", 32'(bus.in_ready), 0);
    do_frame();
    chk("t4_ready_back", 32'(bus.in_ready), 1);
    read_all();

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) do_push($urandom_range(0, 11));
      else if (r < 9) do_frame();
      else read_slot($urandom_range(0, 7));
      if (it % 50 == 49) read_all();
    end

    // Overrun: second frame_tick during the scan
    do_reset();
    do_push(4);
    model_frame(r);
    bus.frame_tick = 1'b1;
    tick_clk();
    bus.frame_tick = 1'b0;
    tick_clk();
    tick_clk();
    bus.frame_tick = 1'b1;
    tick_clk();
    bus.frame_tick = 1'b0;
    m_overrun = 1;
    chk("t6_overrun_set", 32'(bus.overrun), 1);
    wait_scan(cyc, misses, rdy);
    chk("t6_busy_bounded", (cyc < 20) ? 1 : 0, 1);
    read_slot(0);
    do_frame();
    chk("t6_overrun_sticky", 32'(bus.overrun), 1);

    // Reset in the middle of a scan
    do_push(6);
    bus.frame_tick = 1'b1;
    tick_clk();
    bus.frame_tick = 1'b0;
    tick_clk();
    tick_clk();
    reset = 1'b1;
    tick_clk();
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_overrun", 32'(bus.overrun), 0);
    chk("t6_rst_miss", 32'(bus.miss_pulse), 0);
    reset = 1'b0;
    model_reset();
    chk("t6_rst_ready", 32'(bus.in_ready), 1);
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
